cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 123 ++++++++++++
 tb/tb_cdb_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-slot round-robin common data bus arbiter with per-requester holding buffers
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid0,
    output logic [TAG_W-1:0]          cdb_tag0,
    output logic [DATA_W-1:0]         cdb_data0,
    output logic                      cdb_valid1,
    output logic [TAG_W-1:0]          cdb_tag1,
    output logic [DATA_W-1:0]         cdb_data1
);

    localparam int PTR_W = 2;

    // One-entry holding buffer per requester
    logic [NUM_REQ-1:0] buf_valid;
    logic [TAG_W-1:0]   buf_tag  [NUM_REQ];
    logic [DATA_W-1:0]  buf_data [NUM_REQ];

    // Round-robin pointer: requester rr has highest priority this cycle
    logic [PTR_W-1:0]   rr;

    logic               g0_vld;
    logic               g1_vld;
    logic [PTR_W-1:0]   g0_idx;
    logic [PTR_W-1:0]   g1_idx;
    logic [PTR_W-1:0]   scan_idx;
    logic [NUM_REQ-1:0] grant;

    // Pick the first two occupied buffers in rotating priority order starting at rr
    always_comb begin
        g0_vld   = 1'b0;
        g1_vld   = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        scan_idx = '0;
        grant    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr + PTR_W'(k);
            if (buf_valid[scan_idx]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = scan_idx;
                    grant[scan_idx] = 1'b1;
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = scan_idx;
                    grant[scan_idx] = 1'b1;
                end
            end
        end
    end

    // A buffer can take a new result when empty or draining this cycle; never during rst/flush
    always_comb begin
        req_ready = '0;
        if (!rst && !flush) begin
            req_ready = ~buf_valid | grant;
        end
    end

    // Broadcast registers, buffer fill/drain and pointer advance
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid  <= '0;
            rr         <= '0;
            cdb_valid0 <= 1'b0;
            cdb_tag0   <= '0;
            cdb_data0  <= '0;
            cdb_valid1 <= 1'b0;
            cdb_tag1   <= '0;
            cdb_data1  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_tag[i]  <= '0;
                buf_data[i] <= '0;
            end
        end else if (flush) begin
            // Drop everything in flight; the pointer keeps its position
            buf_valid  <= '0;
            cdb_valid0 <= 1'b0;
            cdb_tag0   <= '0;
            cdb_data0  <= '0;
            cdb_valid1 <= 1'b0;
            cdb_tag1   <= '0;
            cdb_data1  <= '0;
        end else begin
            cdb_valid0 <= g0_vld;
            cdb_tag0   <= g0_vld ? buf_tag[g0_idx]  : '0;
            cdb_data0  <= g0_vld ? buf_data[g0_idx] : '0;
            cdb_valid1 <= g1_vld;
            cdb_tag1   <= g1_vld ? buf_tag[g1_idx]  : '0;
            cdb_data1  <= g1_vld ? buf_data[g1_idx] : '0;

            // Next cycle starts just past the last requester served
            if (g1_vld) begin
                rr <= g1_idx + PTR_W'(1);
            end else if (g0_vld) begin
                rr <= g0_idx + PTR_W'(1);
            end

            // Tag 0 means "no result": accepted but never buffered
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (req_tag[i*TAG_W +: TAG_W] != '0)) begin
                    buf_valid[i] <= 1'b1;
                    buf_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
                    buf_data[i]  <= req_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector bench for cdb_arbiter
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   req_valid;
    logic [19:0]  req_tag;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         cdb_valid0;
    logic [4:0]   cdb_tag0;
    logic [31:0]  cdb_data0;
    logic         cdb_valid1;
    logic [4:0]   cdb_tag1;
    logic [31:0]  cdb_data1;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cdb_valid0 (cdb_valid0),
        .cdb_tag0   (cdb_tag0),
        .cdb_data0  (cdb_data0),
        .cdb_valid1 (cdb_valid1),
        .cdb_tag1   (cdb_tag1),
        .cdb_data1  (cdb_data1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         flush;
        logic [3:0]   v;
        logic [19:0]  tag;
        logic [127:0] data;
        logic [3:0]   exp_rdy;
        logic         ev0;
        logic [4:0]   et0;
        logic [31:0]  ed0;
        logic         ev1;
        logic [4:0]   et1;
        logic [31:0]  ed1;
        logic [1:0]   err;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic logic [31:0] dd(input logic [4:0] t);
        return 32'hC0DE_0000 | {27'd0, t};
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic [3:0] v,
                                input logic [4:0] t3, input logic [4:0] t2,
                                input logic [4:0] t1, input logic [4:0] t0,
                                input logic [3:0] rdy,
                                input logic ev0, input logic [4:0] et0,
                                input logic ev1, input logic [4:0] et1,
                                input logic [1:0] err);
        vec_t x;
        x.rst     = r;
        x.flush   = f;
        x.v       = v;
        x.tag     = {t3, t2, t1, t0};
        x.data    = {dd(t3), dd(t2), dd(t1), dd(t0)};
        x.exp_rdy = rdy;
        x.ev0     = ev0;
        x.et0     = ev0 ? et0 : 5'd0;
        x.ed0     = ev0 ? dd(et0) : 32'd0;
        x.ev1     = ev1;
        x.et1     = ev1 ? et1 : 5'd0;
        x.ed1     = ev1 ? dd(et1) : 32'd0;
        x.err     = err;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic [3:0] v,
                         input logic [19:0] t, input logic [127:0] d);
        rst       = r;
        flush     = f;
        req_valid = v;
        req_tag   = t;
        req_data  = d;
    endtask

    initial begin
        //                  rst f  v        t3    t2    t1    t0    rdy      ev0 et0    ev1 et1    rr
        vecs[0]  = mk(1, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 0, 5'd0,  0, 5'd0,  2'd0);
        vecs[1]  = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 0, 5'd0,  0, 5'd0,  2'd0);
        // all four buffers filled with tags 1..4, then drained two per cycle
        vecs[2]  = mk(0, 0, 4'b1111, 5'd4, 5'd3, 5'd2, 5'd1, 4'b1111, 0, 5'd0,  0, 5'd0,  2'd0);
        vecs[3]  = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b0011, 1, 5'd1,  1, 5'd2,  2'd2);
        vecs[4]  = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 1, 5'd3,  1, 5'd4,  2'd0);
        vecs[5]  = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 0, 5'd0,  0, 5'd0,  2'd0);
        // requester 2 streams 5,6,7 back to back
        vecs[6]  = mk(0, 0, 4'b0100, 5'd0, 5'd5, 5'd0, 5'd0, 4'b1111, 0, 5'd0,  0, 5'd0,  2'd0);
        vecs[7]  = mk(0, 0, 4'b0100, 5'd0, 5'd6, 5'd0, 5'd0, 4'b1111, 1, 5'd5,  0, 5'd0,  2'd3);
        vecs[8]  = mk(0, 0, 4'b0100, 5'd0, 5'd7, 5'd0, 5'd0, 4'b1111, 1, 5'd6,  0, 5'd0,  2'd3);
        vecs[9]  = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 1, 5'd7,  0, 5'd0,  2'd3);
        vecs[10] = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 0, 5'd0,  0, 5'd0,  2'd3);
        // tag 0 on requester 1: accepted, never broadcast, rr untouched
        vecs[11] = mk(0, 0, 4'b0010, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 0, 5'd0,  0, 5'd0,  2'd3);
        vecs[12] = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 0, 5'd0,  0, 5'd0,  2'd3);
        // full contention starting at rr=3, refill while draining, held entries retained
        vecs[13] = mk(0, 0, 4'b1111, 5'd11, 5'd10, 5'd9, 5'd8, 4'b1111, 0, 5'd0, 0, 5'd0, 2'd3);
        vecs[14] = mk(0, 0, 4'b1111, 5'd15, 5'd14, 5'd13, 5'd12, 4'b1001, 1, 5'd11, 1, 5'd8, 2'd1);
        vecs[15] = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b0110, 1, 5'd9,  1, 5'd10, 2'd3);
        vecs[16] = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 1, 5'd15, 1, 5'd12, 2'd1);
        vecs[17] = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 0, 5'd0,  0, 5'd0,  2'd1);
        // flush with buffers 0 and 3 occupied
        vecs[18] = mk(0, 0, 4'b1001, 5'd17, 5'd0, 5'd0, 5'd16, 4'b1111, 0, 5'd0, 0, 5'd0, 2'd1);
        vecs[19] = mk(0, 1, 4'b1111, 5'd21, 5'd20, 5'd19, 5'd18, 4'b0000, 0, 5'd0, 0, 5'd0, 2'd1);
        vecs[20] = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 0, 5'd0,  0, 5'd0,  2'd1);
        // reset with three buffers occupied
        vecs[21] = mk(0, 0, 4'b0111, 5'd0, 5'd22, 5'd21, 5'd20, 4'b1111, 0, 5'd0, 0, 5'd0, 2'd1);
        vecs[22] = mk(1, 0, 4'b1111, 5'd26, 5'd25, 5'd24, 5'd23, 4'b0000, 0, 5'd0, 0, 5'd0, 2'd0);
        vecs[23] = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 0, 5'd0,  0, 5'd0,  2'd0);
        vecs[24] = mk(0, 0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b1111, 0, 5'd0,  0, 5'd0,  2'd0);

        drive(1'b1, 1'b0, 4'b0000, 20'd0, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cdb_valid0", {31'd0, cdb_valid0}, 32'd0);
        chk("reset_cdb_valid1", {31'd0, cdb_valid1}, 32'd0);
        chk("reset_rr", {30'd0, dut.rr}, 32'd0);

        for (int n = 0; n < NV; n++) begin
            @(negedge clk);
            drive(vecs[n].rst, vecs[n].flush, vecs[n].v, vecs[n].tag, vecs[n].data);
            #1;
            chk($sformatf("v%0d_req_ready", n), {28'd0, req_ready}, {28'd0, vecs[n].exp_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid0", n), {31'd0, cdb_valid0}, {31'd0, vecs[n].ev0});
            chk($sformatf("v%0d_tag0", n),   {27'd0, cdb_tag0},   {27'd0, vecs[n].et0});
            chk($sformatf("v%0d_data0", n),  cdb_data0,           vecs[n].ed0);
            chk($sformatf("v%0d_valid1", n), {31'd0, cdb_valid1}, {31'd0, vecs[n].ev1});
            chk($sformatf("v%0d_tag1", n),   {27'd0, cdb_tag1},   {27'd0, vecs[n].et1});
            chk($sformatf("v%0d_data1", n),  cdb_data1,           vecs[n].ed1);
            chk($sformatf("v%0d_rr", n),     {30'd0, dut.rr},     {30'd0, vecs[n].err});
            if (cdb_valid0 && cdb_valid1) begin
                checks++;
                if (cdb_tag0 == cdb_tag1) begin
                    errors++;
                    $display("FAIL v%0d_distinct_tags: tag0 %0d tag1 %0d must differ", n, cdb_tag0, cdb_tag1);
                end
            end
        end

        // Single request after reset: one-cycle hold in the buffer, then broadcast
        @(negedge clk);
        drive(1'b1, 1'b0, 4'b0000, 20'd0, 128'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0001, 20'd3, {96'd0, 32'hAAAA_0001});
        @(posedge clk);
        #1;
        chk("single_buffered", {31'd0, dut.buf_valid[0]}, 32'd1);
        chk("single_not_yet_on_cdb", {31'd0, cdb_valid0}, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0);
        @(posedge clk);
        #1;
        chk("single_valid0", {31'd0, cdb_valid0}, 32'd1);
        chk("single_tag0", {27'd0, cdb_tag0}, 32'd3);
        chk("single_data0", cdb_data0, 32'hAAAA_0001);
        chk("single_valid1", {31'd0, cdb_valid1}, 32'd0);
        chk("single_rr", {30'd0, dut.rr}, 32'd1);
        @(posedge clk);
        #1;
        chk("single_no_repeat", {31'd0, cdb_valid0}, 32'd0);

        // Flush with an entry that would otherwise be granted in the same cycle
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0100, {5'd0, 5'd9, 5'd0, 5'd0}, 128'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b0000, 20'd0, 128'd0);
        #1;
        chk("flush_ready_low", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("flush_valid0", {31'd0, cdb_valid0}, 32'd0);
        chk("flush_bufs_empty", {28'd0, dut.buf_valid}, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 20'd0, 128'd0);
        @(posedge clk);
        #1;
        chk("flush_no_stale", {31'd0, cdb_valid0 | cdb_valid1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
